// File: rtl/y86_qword_mem_ctrl.sv
// Quad-word memory controller for the Y86 memory stage.
// Splits one 64-bit load/store into two back-to-back 32-bit RAM accesses
// (low word at the even word address, high word at the odd one) and
// reports completion with a one-cycle done pulse, plus err for requests
// that are not 8-byte aligned.
module y86_qword_mem_ctrl #(
    parameter int RAM_AW = 10,
    parameter int QW     = 64
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [RAM_AW+1:0] i_addr,
    input  logic [QW-1:0]     i_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [QW-1:0]     o_rdata,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic [31:0]       o_ram_din,
    output logic              o_ram_rd,
    output logic              o_ram_wr,
    input  logic [31:0]       i_ram_dout
);

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        WR0,
        WR1,
        DONE,
        ERR
    } stateT;

    stateT               r_state;
    logic [RAM_AW-2:0]   r_pair;
    logic [QW/2-1:0]     r_wdataHi;
    logic [QW-1:0]       r_rdata;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_ramRd;
    logic                r_ramWr;
    logic [RAM_AW-1:0]   r_ramAddr;
    logic [31:0]         r_ramDin;

    logic [RAM_AW-2:0]   w_pair;
    logic                w_misaligned;

    assign w_pair       = i_addr[RAM_AW+1:3];
    assign w_misaligned = (i_addr[2:0] != 3'b000);

    // The low data word goes to the RAM straight from the request in the
    // accept cycle, so only the high word needs to be held for WR1.
    // Outputs are registered alongside the state: each transition loads the
    // output values belonging to the state being entered, so they always
    // match the state register and reset clears them on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_pair    <= '0;
            r_wdataHi <= '0;
            r_rdata   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_ramRd   <= 1'b0;
            r_ramWr   <= 1'b0;
            r_ramAddr <= '0;
            r_ramDin  <= '0;
        end else begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_ramRd   <= 1'b0;
            r_ramWr   <= 1'b0;
            r_ramAddr <= '0;
            r_ramDin  <= '0;
            case (r_state)
                IDLE: begin
                    if (i_req) begin
                        r_pair    <= w_pair;
                        r_wdataHi <= i_wdata[QW-1:QW/2];
                        r_busy    <= 1'b1;
                        if (w_misaligned) begin
                            r_state <= ERR;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (i_we) begin
                            r_state   <= WR0;
                            r_ramWr   <= 1'b1;
                            r_ramAddr <= {w_pair, 1'b0};
                            r_ramDin  <= i_wdata[QW/2-1:0];
                        end else begin
                            r_state   <= RD0;
                            r_ramRd   <= 1'b1;
                            r_ramAddr <= {w_pair, 1'b0};
                        end
                    end
                end
                RD0: begin
                    r_state   <= RD1;
                    r_busy    <= 1'b1;
                    r_ramRd   <= 1'b1;
                    r_ramAddr <= {r_pair, 1'b1};
                end
                RD1: begin
                    r_state              <= RD2;
                    r_busy               <= 1'b1;
                    r_rdata[QW/2-1:0]    <= i_ram_dout;
                end
                RD2: begin
                    r_state              <= DONE;
                    r_busy               <= 1'b1;
                    r_done               <= 1'b1;
                    r_rdata[QW-1:QW/2]   <= i_ram_dout;
                end
                WR0: begin
                    r_state   <= WR1;
                    r_busy    <= 1'b1;
                    r_ramWr   <= 1'b1;
                    r_ramAddr <= {r_pair, 1'b1};
                    r_ramDin  <= r_wdataHi;
                end
                WR1: begin
                    r_state <= DONE;
                    r_busy  <= 1'b1;
                    r_done  <= 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                ERR: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_rdata    = r_rdata;
    assign o_ram_addr = r_ramAddr;
    assign o_ram_din  = r_ramDin;
    assign o_ram_rd   = r_ramRd;
    assign o_ram_wr   = r_ramWr;

endmodule

// File: tb/tb_y86_qword_mem_ctrl.sv
// Self-checking bench for y86_qword_mem_ctrl.
// A 1024x32 RAM with one-cycle read latency is attached to the controller;
// expectations come from a quad-word array model and the latency rules.
module tb_y86_qword_mem_ctrl;

    logic        i_clk;
    logic        i_reset;
    logic        i_req;
    logic        i_we;
    logic [11:0] i_addr;
    logic [63:0] i_wdata;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [63:0] o_rdata;
    logic [9:0]  o_ram_addr;
    logic [31:0] o_ram_din;
    logic        o_ram_rd;
    logic        o_ram_wr;
    logic [31:0] i_ram_dout;

    logic [31:0] ramMem [1024];
    logic [63:0] refMem [512];
    logic [63:0] refRdata;

    logic [9:0]  rdAddrs [$];
    logic [9:0]  wrAddrs [$];
    logic [31:0] wrDins  [$];
    int          bothHigh;
    int          dinLeak;
    int          addrLeak;

    int checkCount;
    int failCount;

    y86_qword_mem_ctrl #(.RAM_AW(10), .QW(64)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_req      (i_req),
        .i_we       (i_we),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_rdata    (o_rdata),
        .o_ram_addr (o_ram_addr),
        .o_ram_din  (o_ram_din),
        .o_ram_rd   (o_ram_rd),
        .o_ram_wr   (o_ram_wr),
        .i_ram_dout (i_ram_dout)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Word RAM: synchronous write, read data one cycle after the strobe.
    always @(posedge i_clk) begin
        if (o_ram_wr) ramMem[o_ram_addr] <= o_ram_din;
        if (o_ram_rd) i_ram_dout <= ramMem[o_ram_addr];
    end

    // Record the RAM traffic of each transaction and any strobe misbehaviour.
    always @(negedge i_clk) begin
        if (o_ram_rd) rdAddrs.push_back(o_ram_addr);
        if (o_ram_wr) begin
            wrAddrs.push_back(o_ram_addr);
            wrDins.push_back(o_ram_din);
        end
        if (o_ram_rd && o_ram_wr) bothHigh++;
        if (!o_ram_wr && o_ram_din != 32'h0) dinLeak++;
        if ((!o_busy || o_done) && o_ram_addr != 10'h0) addrLeak++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents a request; the caller is positioned before a falling edge.
    task automatic applyStimulus(input logic we, input logic [11:0] addr, input logic [63:0] wdata);
        @(negedge i_clk);
        rdAddrs.delete();
        wrAddrs.delete();
        wrDins.delete();
        i_req   = 1'b1;
        i_we    = we;
        i_addr  = addr;
        i_wdata = wdata;
    endtask

    // Waits for the accepting edge, then checks latency, status, data and traffic.
    task automatic awaitCompletion(input logic we, input logic [11:0] addr, input logic [63:0] wdata);
        int         n;
        int         expLat;
        int         expRd;
        int         expWr;
        logic       expErr;
        logic [8:0] p;
        p      = addr[11:3];
        expErr = (addr[2:0] != 3'b000);
        if (expErr)  expLat = 1;
        else if (we) expLat = 3;
        else         expLat = 4;
        expRd = (!expErr && !we) ? 2 : 0;
        expWr = (!expErr && we) ? 2 : 0;
        @(posedge i_clk);
        #1;
        i_req = 1'b0;
        checkOutput("busyAfterAccept", 64'(o_busy), 64'd1);
        n = 1;
        while (!o_done && n < 12) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        if (!expErr) begin
            if (we) refMem[p] = wdata;
            else    refRdata  = refMem[p];
        end
        checkOutput("doneLatency", 64'(n), 64'(expLat));
        checkOutput("err", 64'(o_err), 64'(expErr));
        checkOutput("rdata", o_rdata, refRdata);
        @(posedge i_clk);
        #1;
        checkOutput("idleAfterDone", 64'({o_busy, o_done, o_err}), 64'd0);
        checkOutput("rdStrobes", 64'(rdAddrs.size()), 64'(expRd));
        checkOutput("wrStrobes", 64'(wrAddrs.size()), 64'(expWr));
        if (rdAddrs.size() == 2) begin
            checkOutput("rdAddrLo", 64'(rdAddrs[0]), 64'({p, 1'b0}));
            checkOutput("rdAddrHi", 64'(rdAddrs[1]), 64'({p, 1'b1}));
        end
        if (wrAddrs.size() == 2) begin
            checkOutput("wrAddrLo", 64'(wrAddrs[0]), 64'({p, 1'b0}));
            checkOutput("wrAddrHi", 64'(wrAddrs[1]), 64'({p, 1'b1}));
            checkOutput("wrDinLo", 64'(wrDins[0]), 64'(wdata[31:0]));
            checkOutput("wrDinHi", 64'(wrDins[1]), 64'(wdata[63:32]));
        end
    endtask

    task automatic runTxn(input logic we, input logic [11:0] addr, input logic [63:0] wdata);
        applyStimulus(we, addr, wdata);
        awaitCompletion(we, addr, wdata);
    endtask

    initial begin
        int         doneAt [$];
        int         sawDone;
        logic [8:0] p;
        logic [2:0] off;
        logic [11:0] a;

        checkCount = 0;
        failCount  = 0;
        bothHigh   = 0;
        dinLeak    = 0;
        addrLeak   = 0;
        refRdata   = 64'h0;
        for (int i = 0; i < 1024; i++) ramMem[i] = $urandom;
        for (int i = 0; i < 512; i++) refMem[i] = {ramMem[2*i+1], ramMem[2*i]};

        // Reset held with a pending aligned load.
        i_reset = 1'b1;
        i_req   = 1'b1;
        i_we    = 1'b0;
        i_addr  = 12'h008;
        i_wdata = 64'h0;
        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("resetStatus", 64'({o_busy, o_done, o_err, o_ram_rd, o_ram_wr}), 64'd0);
        checkOutput("resetRdata", o_rdata, 64'h0);
        checkOutput("resetRamBus", 64'({o_ram_addr, o_ram_din}), 64'd0);
        @(negedge i_clk);
        rdAddrs.delete();
        wrAddrs.delete();
        wrDins.delete();
        i_reset = 1'b0;
        awaitCompletion(1'b0, 12'h008, 64'h0);

        // Directed cases.
        runTxn(1'b1, 12'h010, 64'h1122334455667788);
        runTxn(1'b0, 12'h010, 64'h0);
        runTxn(1'b0, 12'h00C, 64'h0);
        runTxn(1'b1, 12'hFF8, 64'hDEADBEEFCAFEF00D);
        runTxn(1'b0, 12'hFF8, 64'h0);
        checkOutput("noWrapWord0", 64'(ramMem[0]), 64'(refMem[0][31:0]));
        checkOutput("noWrapWord1", 64'(ramMem[1]), 64'(refMem[0][63:32]));

        // Reset while the second read is on the bus.
        applyStimulus(1'b0, 12'h010, 64'h0);
        @(posedge i_clk);
        #1;
        i_req = 1'b0;
        checkOutput("rd0Addr", 64'({o_ram_rd, o_ram_addr}), 64'({1'b1, 10'd4}));
        @(posedge i_clk);
        #1;
        checkOutput("rd1Addr", 64'({o_ram_rd, o_ram_addr}), 64'({1'b1, 10'd5}));
        @(negedge i_clk);
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        refRdata = 64'h0;
        checkOutput("midResetStatus", 64'({o_busy, o_done, o_ram_rd, o_ram_wr}), 64'd0);
        checkOutput("midResetRdata", o_rdata, refRdata);
        @(negedge i_clk);
        i_reset = 1'b0;
        sawDone = 0;
        repeat (3) begin
            @(posedge i_clk);
            #1;
            if (o_done) sawDone++;
        end
        checkOutput("midResetNoDone", 64'(sawDone), 64'd0);
        runTxn(1'b0, 12'h010, 64'h0);

        // Request held high: loads are re-accepted every 5 cycles.
        applyStimulus(1'b0, 12'hFF8, 64'h0);
        refRdata = refMem[511];
        for (int n = 1; n <= 12; n++) begin
            @(posedge i_clk);
            #1;
            if (o_done) doneAt.push_back(n);
            if (doneAt.size() == 2) begin
                i_req = 1'b0;
                break;
            end
        end
        checkOutput("heldReqDones", 64'(doneAt.size()), 64'd2);
        if (doneAt.size() == 2) begin
            checkOutput("heldReqFirst", 64'(doneAt[0]), 64'd4);
            checkOutput("heldReqSecond", 64'(doneAt[1]), 64'd9);
        end
        checkOutput("heldReqRdata", o_rdata, refRdata);
        @(posedge i_clk);
        #1;

        // Randomised mix of loads, stores and misaligned requests.
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 9))
                0:       p = 9'd511;
                1:       p = 9'd0;
                2, 3:    p = 9'($urandom_range(0, 3));
                default: p = 9'($urandom_range(0, 511));
            endcase
            off = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            a   = {p, off};
            runTxn(1'($urandom_range(0, 1)), a, {$urandom, $urandom});
        end

        checkOutput("strobeOverlap", 64'(bothHigh), 64'd0);
        checkOutput("dinOutsideWrite", 64'(dinLeak), 64'd0);
        checkOutput("addrWhenIdle", 64'(addrLeak), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
